fir_xifu_ctrl: RTL and testbench

FIR_XIFU_CTRL -- requirements
Module: fir_xifu_ctrl

---
 rtl/fir_xifu_pkg.sv | 50 +++++
 rtl/fir_xifu_ctrl_slot.sv | 57 +++++
 rtl/fir_xifu_ctrl.sv | 83 ++++++++
 tb/tb_fir_xifu_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_xifu_pkg.sv
// Shared XIF controller types: ID width, interface structs and the per-ID slot state.
// Slot bits map to states as {kill, commit, issue}; see slot_state().
package fir_xifu_pkg;

  localparam int unsigned X_ID_WIDTH = 4;
  localparam int unsigned X_ID_MAX   = 2**X_ID_WIDTH;

  typedef logic [X_ID_WIDTH-1:0] x_id_t;
  typedef logic [X_ID_MAX-1:0]   x_vec_t;

  typedef struct packed {
    logic  issue;
    x_id_t id;
  } id2ctrl_t;

  typedef struct packed {
    x_vec_t commit;
  } ctrl2ex_t;

  typedef struct packed {
    x_vec_t issue;
    x_vec_t commit;
    x_vec_t kill;
  } ctrl2wb_t;

  typedef struct packed {
    x_vec_t clear;
  } wb2ctrl_t;

  typedef struct packed {
    logic  valid;
    x_id_t id;
    logic  kill;
  } commit_t;

  typedef enum logic [1:0] {
    ST_FREE,
    ST_ISSUED,
    ST_COMMITTED,
    ST_KILLED
  } ctrl_state_t;

  function automatic ctrl_state_t slot_state(logic iss, logic com, logic kil);
    if (kil)      return ST_KILLED;
    else if (com) return ST_COMMITTED;
    else if (iss) return ST_ISSUED;
    else          return ST_FREE;
  endfunction

endpackage

// File: rtl/fir_xifu_ctrl_slot.sv
// Tracking state for a single XIF ID; one instance per ID.
//   state     | meaning
//   FREE      | ID available for issue
//   ISSUED    | issued, waiting for commit or kill
//   COMMITTED | committed, result may be written back
//   KILLED    | killed, result must be discarded
module fir_xifu_ctrl_slot
  import fir_xifu_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic issue_ev,
  input  logic ack_ev,
  input  logic ack_kill,
  input  logic clear,
  output logic issue_q,
  output logic commit_q,
  output logic kill_q
);

  ctrl_state_t state;
  logic        issue_d, commit_d, kill_d;

  assign state = slot_state(issue_q, commit_q, kill_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      issue_q  <= 1'b0;
      commit_q <= 1'b0;
      kill_q   <= 1'b0;
    end else begin
      issue_q  <= issue_d;
      commit_q <= commit_d;
      kill_q   <= kill_d;
    end
  end

  // Priority: issue (may carry a same-cycle ack) > clear > ack on an ISSUED slot.
  always_comb begin
    issue_d  = issue_q;
    commit_d = commit_q;
    kill_d   = kill_q;
    if (issue_ev) begin
      issue_d  = 1'b1;
      commit_d = ack_ev & ~ack_kill;
      kill_d   = ack_ev & ack_kill;
    end else if (clear) begin
      issue_d  = 1'b0;
      commit_d = 1'b0;
      kill_d   = 1'b0;
    end else if (ack_ev && state == ST_ISSUED) begin
      commit_d = ~ack_kill;
      kill_d   = ack_kill;
    end
  end

endmodule

// File: rtl/fir_xifu_ctrl.sv
// XIF issue/commit controller: per-ID slots, in-flight counter and optional sticky
// protocol error flag (enabled by defining FIR_XIFU_CTRL_ERR_EN).
module fir_xifu_ctrl
  import fir_xifu_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH = fir_xifu_pkg::X_ID_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  id2ctrl_t            id2ctrl_i,
  input  commit_t             commit_i,
  input  wb2ctrl_t            wb2ctrl_i,
  output logic                issue_ready_o,
  output ctrl2ex_t            ctrl2ex_o,
  output ctrl2wb_t            ctrl2wb_o,
  output logic [X_ID_WIDTH:0] inflight_o,
  output logic                err_o
);

  if (X_ID_WIDTH != fir_xifu_pkg::X_ID_WIDTH) begin : g_width_check
    $error("X_ID_WIDTH must match fir_xifu_pkg::X_ID_WIDTH");
  end

  x_vec_t              issue_q, commit_q, kill_q;
  logic                issue_fire;
  logic [X_ID_WIDTH:0] inflight_q, release_cnt;

  assign issue_ready_o = ~issue_q[id2ctrl_i.id] | wb2ctrl_i.clear[id2ctrl_i.id];
  assign issue_fire    = id2ctrl_i.issue & issue_ready_o;

  for (genvar g = 0; g < X_ID_MAX; g++) begin : g_slot
    fir_xifu_ctrl_slot u_slot (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .issue_ev (issue_fire && id2ctrl_i.id == x_id_t'(g)),
      .ack_ev   (commit_i.valid && commit_i.id == x_id_t'(g)),
      .ack_kill (commit_i.kill),
      .clear    (wb2ctrl_i.clear[g]),
      .issue_q  (issue_q[g]),
      .commit_q (commit_q[g]),
      .kill_q   (kill_q[g])
    );
  end

  assign ctrl2wb_o.issue  = issue_q;
  assign ctrl2wb_o.commit = commit_q;
  assign ctrl2wb_o.kill   = kill_q;
  assign ctrl2ex_o.commit = commit_q & ~kill_q;

  // A clear only releases a slot that was holding an issued ID.
  always_comb begin
    release_cnt = '0;
    for (int i = 0; i < X_ID_MAX; i++) begin
      release_cnt = release_cnt + {X_ID_WIDTH'(0), wb2ctrl_i.clear[i] & issue_q[i]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) inflight_q <= '0;
    else         inflight_q <= inflight_q + {X_ID_WIDTH'(0), issue_fire} - release_cnt;
  end

  assign inflight_o = inflight_q;

`ifdef FIR_XIFU_CTRL_ERR_EN
  logic err_q, ack_on_issued, bad_ack, bad_issue;

  assign ack_on_issued = issue_q[commit_i.id] & ~commit_q[commit_i.id] & ~kill_q[commit_i.id];
  assign bad_ack       = commit_i.valid & ~ack_on_issued &
                         ~(issue_fire && id2ctrl_i.id == commit_i.id);
  assign bad_issue     = id2ctrl_i.issue & ~issue_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_q | bad_ack | bad_issue;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Self-checking bench for fir_xifu_ctrl: behavioural slot model feeding an expected-result queue.
module tb_fir_xifu_ctrl;
  import fir_xifu_pkg::*;

  typedef struct packed {
    x_vec_t              iss;
    x_vec_t              com;
    x_vec_t              kil;
    x_vec_t              exc;
    logic [X_ID_WIDTH:0] infl;
    logic                err;
  } snap_t;

`ifdef FIR_XIFU_CTRL_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  id2ctrl_t            id2ctrl;
  commit_t             commit;
  wb2ctrl_t            wb2ctrl;
  logic                issue_ready;
  ctrl2ex_t            ctrl2ex;
  ctrl2wb_t            ctrl2wb;
  logic [X_ID_WIDTH:0] inflight;
  logic                err;

  int     checks = 0;
  int     failures = 0;
  snap_t  exp_q[$];
  x_vec_t m_iss = '0, m_com = '0, m_kil = '0;
  logic   m_err = 1'b0;

  always #5 clk = ~clk;

  fir_xifu_ctrl #(.X_ID_WIDTH(X_ID_WIDTH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .id2ctrl_i     (id2ctrl),
    .commit_i      (commit),
    .wb2ctrl_i     (wb2ctrl),
    .issue_ready_o (issue_ready),
    .ctrl2ex_o     (ctrl2ex),
    .ctrl2wb_o     (ctrl2wb),
    .inflight_o    (inflight),
    .err_o         (err)
  );

  function automatic snap_t dut_snap();
    return {ctrl2wb.issue, ctrl2wb.commit, ctrl2wb.kill, ctrl2ex.commit, inflight, err};
  endfunction

  function automatic logic model_ready();
    return !m_iss[id2ctrl.id] || wb2ctrl.clear[id2ctrl.id];
  endfunction

  task automatic idle();
    id2ctrl = '0;
    commit  = '0;
    wb2ctrl = '0;
  endtask

  // Advance the model by the stimulus currently applied, queue the expected outputs, clock once.
  task automatic step();
    snap_t  e;
    logic   rdy, fire, was_issued;
    x_vec_t n_iss, n_com, n_kil;
    n_iss = m_iss; n_com = m_com; n_kil = m_kil;
    rdy  = model_ready();
    fire = id2ctrl.issue && rdy;
    was_issued = m_iss[commit.id] && !m_com[commit.id] && !m_kil[commit.id];
    for (int i = 0; i < X_ID_MAX; i++) begin
      if (fire && int'(id2ctrl.id) == i) begin
        n_iss[i] = 1'b1;
        n_com[i] = commit.valid && int'(commit.id) == i && !commit.kill;
        n_kil[i] = commit.valid && int'(commit.id) == i && commit.kill;
      end else if (wb2ctrl.clear[i]) begin
        n_iss[i] = 1'b0; n_com[i] = 1'b0; n_kil[i] = 1'b0;
      end else if (commit.valid && int'(commit.id) == i && m_iss[i] && !m_com[i] && !m_kil[i]) begin
        n_com[i] = !commit.kill;
        n_kil[i] = commit.kill;
      end
    end
    if (ERR_ON && ((commit.valid && !was_issued && !(fire && id2ctrl.id == commit.id)) ||
                   (id2ctrl.issue && !rdy)))
      m_err = 1'b1;
    if (!rst_n) begin
      n_iss = '0; n_com = '0; n_kil = '0; m_err = 1'b0;
    end
    m_iss = n_iss; m_com = n_com; m_kil = n_kil;
    e.iss = n_iss; e.com = n_com; e.kil = n_kil;
    e.exc = n_com & ~n_kil;
    e.infl = ($countones(n_iss)) & ((1 << (X_ID_WIDTH + 1)) - 1);
    e.err = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic free_all();
    idle();
    wb2ctrl.clear = '1;
    step();
    void'(exp_q.pop_front());
    idle();
  endtask

  task automatic test_reset();
    snap_t got, e;
    idle();
    rst_n = 1'b0;
    step();
    got = dut_snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL reset_state: got %h exp %h", got, e); end
    checks++;
    if (got !== '0) begin failures++; $display("FAIL reset_zero: got %h exp 0", got); end
    rst_n = 1'b1;
    for (int i = 0; i < X_ID_MAX; i++) begin
      id2ctrl.id = x_id_t'(i);
      #1;
      checks++;
      if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_ready id=%0d: got %b exp 1", i, issue_ready); end
    end
    idle();
  endtask

  task automatic test_issue_commit();
    snap_t got, e;
    id2ctrl = '{issue: 1'b1, id: 4'd3};
    step();
    got = dut_snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL issue3: got %h exp %h", got, e); end
    checks++;
    if (ctrl2wb.issue[3] !== 1'b1) begin failures++; $display("FAIL issue3_bit: got %b exp 1", ctrl2wb.issue[3]); end
    idle();
    commit = '{valid: 1'b1, id: 4'd3, kill: 1'b0};
    step();
    got = dut_snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL commit3: got %h exp %h", got, e); end
    checks++;
    if (ctrl2ex.commit !== 16'h0008 || inflight !== 5'd1) begin
      failures++; $display("FAIL commit3_ex: got %h/%0d exp 0008/1", ctrl2ex.commit, inflight);
    end
    free_all();
  endtask

  task automatic test_kill_clear();
    snap_t got, e;
    id2ctrl = '{issue: 1'b1, id: 4'd5};
    step();
    got = dut_snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL issue5: got %h exp %h", got, e); end
    idle();
    commit = '{valid: 1'b1, id: 4'd5, kill: 1'b1};
    step();
    got = dut_snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL kill5: got %h exp %h", got, e); end
    checks++;
    if (ctrl2wb.kill[5] !== 1'b1 || ctrl2ex.commit[5] !== 1'b0) begin
      failures++; $display("FAIL kill5_bits: got kill=%b ex=%b exp 1/0", ctrl2wb.kill[5], ctrl2ex.commit[5]);
    end
    idle();
    wb2ctrl.clear[5] = 1'b1;
    step();
    got = dut_snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL clear5: got %h exp %h", got, e); end
    checks++;
    if (ctrl2wb.kill[5] !== 1'b0 || ctrl2wb.issue[5] !== 1'b0 || inflight !== 5'd0) begin
      failures++; $display("FAIL clear5_free: got kill=%b iss=%b infl=%0d exp 0/0/0", ctrl2wb.kill[5], ctrl2wb.issue[5], inflight);
    end
    idle();
  endtask

  task automatic test_clear_issue();
    snap_t got, e;
    id2ctrl = '{issue: 1'b1, id: 4'd2};
    commit  = '{valid: 1'b1, id: 4'd2, kill: 1'b0};
    step();
    void'(exp_q.pop_front());
    idle();
    id2ctrl = '{issue: 1'b1, id: 4'd2};
    wb2ctrl.clear[2] = 1'b1;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin failures++; $display("FAIL clr_iss_ready: got %b exp 1", issue_ready); end
    step();
    got = dut_snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL clr_iss: got %h exp %h", got, e); end
    checks++;
    if (ctrl2wb.issue[2] !== 1'b1 || ctrl2wb.commit[2] !== 1'b0 || inflight !== 5'd1) begin
      failures++; $display("FAIL clr_iss_bits: got iss=%b com=%b infl=%0d exp 1/0/1", ctrl2wb.issue[2], ctrl2wb.commit[2], inflight);
    end
    free_all();
  endtask

  task automatic test_reject();
    snap_t got, e;
    id2ctrl = '{issue: 1'b1, id: 4'd7};
    step();
    void'(exp_q.pop_front());
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin failures++; $display("FAIL reject_ready: got %b exp 0", issue_ready); end
    step();
    got = dut_snap(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL reject: got %h exp %h", got, e); end
    checks++;
    if (ctrl2wb.issue[7] !== 1'b1 || inflight !== 5'd1 || err !== ERR_ON) begin
      failures++; $display("FAIL reject_bits: got iss=%b infl=%0d err=%b exp 1/1/%b", ctrl2wb.issue[7], inflight, err, ERR_ON);
    end
    free_all();
  endtask

  task automatic test_fill();
    snap_t got, e;
    for (int i = 0; i < X_ID_MAX; i++) begin
      id2ctrl = '{issue: 1'b1, id: x_id_t'(i)};
      step();
      got = dut_snap(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL fill id=%0d: got %h exp %h", i, got, e); end
    end
    idle();
    checks++;
    if (inflight !== 5'd16) begin failures++; $display("FAIL fill_count: got %0d exp 16", inflight); end
    for (int i = 0; i < X_ID_MAX; i += 5) begin
      id2ctrl.id = x_id_t'(i);
      #1;
      checks++;
      if (issue_ready !== 1'b0) begin failures++; $display("FAIL full_ready id=%0d: got %b exp 0", i, issue_ready); end
    end
    idle();
    wb2ctrl.clear = '1;
    step();
    got = dut_snap(); e = exp_q.pop_front(); checks++;
    if (got !== e || inflight !== 5'd0) begin failures++; $display("FAIL drain: got %h exp %h", got, e); end
    idle();
  endtask

  task automatic test_reset_mid();
    snap_t got, e;
    id2ctrl = '{issue: 1'b1, id: 4'd1};
    commit  = '{valid: 1'b1, id: 4'd1, kill: 1'b0};
    step();
    got = dut_snap(); e = exp_q.pop_front(); checks++;
    if (got !== e || ctrl2ex.commit !== 16'h0002) begin
      failures++; $display("FAIL iss_com1: got %h exp %h", got, e);
    end
    id2ctrl = '{issue: 1'b1, id: 4'd4};
    commit  = '{valid: 1'b1, id: 4'd9, kill: 1'b0};
    rst_n = 1'b0;
    step();
    got = dut_snap(); e = exp_q.pop_front(); checks++;
    if (got !== e || got !== '0) begin failures++; $display("FAIL mid_reset: got %h exp %h", got, e); end
    rst_n = 1'b1;
    idle();
    id2ctrl.id = 4'd1;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b exp 1", issue_ready); end
    idle();
  endtask

  task automatic test_back_to_back();
    snap_t got, e;
    logic  rdy;
    for (int n = 0; n < 300; n++) begin
      id2ctrl.issue = 1'($urandom_range(0, 1));
      id2ctrl.id    = x_id_t'($urandom_range(0, X_ID_MAX - 1));
      commit.valid  = 1'($urandom_range(0, 1));
      commit.id     = $urandom_range(0, 2) == 0 ? id2ctrl.id : x_id_t'($urandom_range(0, X_ID_MAX - 1));
      commit.kill   = 1'($urandom_range(0, 1));
      wb2ctrl.clear = $urandom_range(0, 2) == 0 ? x_vec_t'($urandom) : '0;
      #1;
      rdy = model_ready();
      checks++;
      if (issue_ready !== rdy) begin failures++; $display("FAIL rand_ready n=%0d: got %b exp %b", n, issue_ready, rdy); end
      step();
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL rand_queue n=%0d: got empty exp entry", n);
      end else begin
        got = dut_snap(); e = exp_q.pop_front();
        if (got !== e) begin failures++; $display("FAIL rand n=%0d: got %h exp %h", n, got, e); end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_issue_commit();
    test_kill_clear();
    test_clear_issue();
    test_reject();
    test_fill();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
